// File: rtl/karatsuba_64.sv
// 64x64 unsigned multiplier, one Karatsuba level, full 128-bit product.
// Latency 2 edges, one result per clock, free-running with no backpressure.
module karatsuba_64 (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  x,
    input  logic [63:0]  y,
    output logic [127:0] product
);

    logic [31:0]  w_xh, w_xl, w_yh, w_yl;
    logic [32:0]  w_sx, w_sy;
    logic [63:0]  w_a, w_b;
    logic [65:0]  w_c;

    logic [63:0]  r_a, r_b;
    logic [65:0]  r_c;

    logic [65:0]  w_m;
    logic [127:0] w_sum;

    assign w_xh = x[63:32];
    assign w_xl = x[31:0];
    assign w_yh = y[63:32];
    assign w_yl = y[31:0];

    // Half sums keep their carry so the 33x33 product stays exact.
    assign w_sx = {1'b0, w_xh} + {1'b0, w_xl};
    assign w_sy = {1'b0, w_yh} + {1'b0, w_yl};

    assign w_a = {32'd0, w_xh} * {32'd0, w_yh};
    assign w_b = {32'd0, w_xl} * {32'd0, w_yl};
    assign w_c = {33'd0, w_sx} * {33'd0, w_sy};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else begin
            r_a <= w_a;
            r_b <= w_b;
            r_c <= w_c;
        end
    end

    // m = xh*yl + xl*yh, never negative and fits in 66 bits.
    assign w_m   = r_c - {2'b00, r_a} - {2'b00, r_b};
    assign w_sum = {r_a, 64'd0} + {30'd0, w_m, 32'd0} + {64'd0, r_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else begin
            product <= w_sum;
        end
    end

endmodule

// File: tb/tb_karatsuba_64.sv
module tb_karatsuba_64;

    logic         clk;
    logic         rst;
    logic [63:0]  x;
    logic [63:0]  y;
    logic [127:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    karatsuba_64 dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .y       (y),
        .product (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: a two-deep delay line of plain 128-bit products.
    logic [127:0] m_q1 = '0;
    logic [127:0] m_q2 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q1 = '0;
            m_q2 = '0;
        end else begin
            m_q2 = m_q1;
            m_q1 = {64'd0, x} * {64'd0, y};
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if (product !== m_q2) begin
            n_bad++;
            $display("FAIL model t=%0t x=%h y=%h got=%h want=%h", $time, x, y, product, m_q2);
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [63:0] xv, input logic [63:0] yv,
                         input logic [127:0] ev, input string nm);
        @(posedge clk); #1;
        x = xv;
        y = yv;
        @(posedge clk);
        @(posedge clk); #2;
        check(nm, product, ev);
    endtask

    int bits [4] = '{0, 31, 32, 63};

    initial begin
        rst = 1'b1;
        x   = 64'hFFFF_FFFF_FFFF_FFFF;
        y   = 64'hFFFF_FFFF_FFFF_FFFF;
        #3;
        check("reset_async", product, 128'd0);

        // Release and see max*max after exactly two edges.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #2;
        check("post_rst_edge1", product, 128'd0);
        @(posedge clk); #2;
        check("max_x_max", product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        apply(64'd3, 64'd5, 128'd15, "small_3x5");
        apply(64'd0, 64'hDEAD_BEEF_CAFE_F00D, 128'd0, "zero_x");
        apply(64'd1, 64'h0123_4567_89AB_CDEF, 128'h0123_4567_89AB_CDEF, "one_x");
        apply(64'h0000_0001_FFFF_FFFF, 64'h0000_0001_FFFF_FFFF,
              128'h0000_0000_0000_0003_FFFF_FFFC_0000_0001, "sum_carry");
        apply(64'h8000_0000_0000_0000, 64'd2, 128'h1_0000_0000_0000_0000, "msb_x2");

        foreach (bits[i]) begin
            foreach (bits[j]) begin
                apply(64'd1 << bits[i], 64'd1 << bits[j],
                      128'd1 << (bits[i] + bits[j]), $sformatf("onehot_%0d_%0d", bits[i], bits[j]));
            end
        end

        // Back-to-back random operands, checked every cycle by the model.
        repeat (1000) begin
            @(posedge clk); #1;
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
        end

        // Mid-stream reset between edges: in-flight results vanish.
        @(posedge clk); #1;
        x = 64'd7;  y = 64'd9;
        @(posedge clk); #1;
        x = 64'd11; y = 64'd13;
        @(posedge clk); #1;
        x = 64'd3;  y = 64'd5;
        #1;
        check("pre_reset_val", product, 128'd63);
        rst = 1'b1;
        #1;
        check("mid_reset_async", product, 128'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #2;
        check("mid_reset_out1", product, 128'd0);
        @(posedge clk); #2;
        check("mid_reset_out2", product, 128'd15);

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
